phy_tx_mutex_arbiter: RTL

- Owns the four PHY-TX FIFO write ports and shares them between N_REQ frame sources: the forwarding engines and the control-frame issuer.
- Each source asks for a one-hot or multi-hot port mask and receives an ownership mask back. It owns its ports when the returned mask equals its request.
- Grants are all-or-nothing and round-robin, so no source can hold one port while waiting on another (no deadlock).
- The owner's byte stream is muxed onto each granted PHY FIFO. Non-owner writes are masked out and flagged.

---
 rtl/phy_tx_mutex_arbiter_pkg.sv | 33 +++
 rtl/phy_tx_mutex_arbiter_rr_pick.sv | 29 ++
 rtl/phy_tx_mutex_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/phy_tx_mutex_arbiter_pkg.sv
// Shared constants and width helpers for the PHY-TX port mutex arbiter.
package phy_tx_mutex_arbiter_pkg;

  localparam int unsigned N_REQ_DEFAULT  = 5;
  localparam int unsigned N_PORT_DEFAULT = 4;
  localparam int unsigned BYTE_W         = 8;

  localparam int unsigned PORT0_IDX = 0;
  localparam int unsigned PORT1_IDX = 1;
  localparam int unsigned PORT2_IDX = 2;
  localparam int unsigned PORT3_IDX = 3;

  // Highest requester index is reserved for the control-frame issuer.
  localparam int unsigned CTRL_REQ_IDX = N_REQ_DEFAULT - 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned value);
    return (clog2(value) > 0) ? clog2(value) : 1;
  endfunction

endpackage

// File: rtl/phy_tx_mutex_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr.
module phy_tx_mutex_arbiter_rr_pick
  import phy_tx_mutex_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IW-1:0]    rr_ptr,
  output logic             gnt_vld,
  output logic [IW-1:0]    gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest eligible wins.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % int'(N_REQ);
      if (eligible[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/phy_tx_mutex_arbiter.sv
// All-or-nothing round-robin ownership of the PHY-TX FIFO write ports,
// with a zero-latency data mux from each port's owner onto its FIFO.
module phy_tx_mutex_arbiter
  import phy_tx_mutex_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEFAULT,
  parameter int unsigned N_PORT   = N_PORT_DEFAULT,
  parameter int unsigned MAX_HOLD = 4096
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic [N_REQ*N_PORT-1:0]    mutex_req,
  output logic [N_REQ*N_PORT-1:0]    mutex_val,
  input  logic [N_REQ*BYTE_W-1:0]    req_din,
  input  logic [N_REQ-1:0]           req_del,
  input  logic [N_REQ*N_PORT-1:0]    req_wren,
  output logic [N_PORT*BYTE_W-1:0]   phy_din,
  output logic [N_PORT-1:0]          phy_del,
  output logic [N_PORT-1:0]          phy_wren,
  output logic                       err_wren,
  output logic                       err_proto,
  output logic [N_REQ-1:0]           hold_overrun
);

  localparam int unsigned IW       = idx_width(N_REQ);
  localparam int unsigned HW       = (MAX_HOLD > 0) ? idx_width(MAX_HOLD + 1) : 1;
  localparam int unsigned HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  logic [N_PORT-1:0] owner_vld;
  logic [IW-1:0]     owner_idx [N_PORT];
  logic [IW-1:0]     rr_ptr;
  logic [HW-1:0]     hold_cnt  [N_REQ];

  logic [N_PORT-1:0] req_m [N_REQ];
  logic [N_PORT-1:0] val_m [N_REQ];
  logic [N_REQ-1:0]  holding;
  logic [N_REQ-1:0]  release_c;
  logic [N_REQ-1:0]  chg_c;
  logic [N_REQ-1:0]  elig_c;
  logic [N_PORT-1:0] port_rel_c;
  logic [N_PORT-1:0] gnt_mask_c;
  logic              err_wren_c;
  logic              gnt_vld;
  logic [IW-1:0]     gnt_idx;

  // Per-requester view: holding, release/mask-change, and grant eligibility.
  always_comb begin
    holding   = '0;
    release_c = '0;
    chg_c     = '0;
    elig_c    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_m[i]     = mutex_req[i*N_PORT +: N_PORT];
      val_m[i]     = mutex_val[i*N_PORT +: N_PORT];
      holding[i]   = |val_m[i];
      release_c[i] = holding[i] && (req_m[i] != val_m[i]);
      chg_c[i]     = release_c[i] && (|req_m[i]);
      // Ports freed this cycle are still owned here, so they are never re-granted same cycle.
      elig_c[i]    = (|req_m[i]) && !holding[i] && ((req_m[i] & owner_vld) == '0);
    end
  end

  phy_tx_mutex_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .eligible (elig_c),
    .rr_ptr   (rr_ptr),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );

  // Per-port release, the granted mask, and non-owner write detection.
  always_comb begin
    port_rel_c = '0;
    gnt_mask_c = '0;
    err_wren_c = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt_vld && (gnt_idx == IW'(i))) gnt_mask_c = req_m[i];
      for (int p = 0; p < int'(N_PORT); p++) begin
        if (owner_vld[p] && (owner_idx[p] == IW'(i)) && release_c[i]) port_rel_c[p] = 1'b1;
        if (req_wren[i*N_PORT + p] && !(owner_vld[p] && (owner_idx[p] == IW'(i))))
          err_wren_c = 1'b1;
      end
    end
  end

  // Owner data mux; unowned ports drive all zeros.
  always_comb begin
    phy_din  = '0;
    phy_del  = '0;
    phy_wren = '0;
    for (int p = 0; p < int'(N_PORT); p++) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (owner_vld[p] && (owner_idx[p] == IW'(i))) begin
          phy_din[p*BYTE_W +: BYTE_W] = req_din[i*BYTE_W +: BYTE_W];
          phy_del[p]                  = req_del[i];
          phy_wren[p]                 = req_wren[i*N_PORT + p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      owner_vld    <= '0;
      rr_ptr       <= '0;
      mutex_val    <= '0;
      err_wren     <= 1'b0;
      err_proto    <= 1'b0;
      hold_overrun <= '0;
      for (int p = 0; p < int'(N_PORT); p++) owner_idx[p] <= '0;
      for (int i = 0; i < int'(N_REQ); i++) hold_cnt[i] <= '0;
    end else begin
      err_wren  <= err_wren_c;
      err_proto <= |chg_c;

      // Release first; a grant only ever touches ports that were free this cycle.
      for (int p = 0; p < int'(N_PORT); p++) begin
        if (port_rel_c[p]) owner_vld[p] <= 1'b0;
        if (gnt_mask_c[p]) begin
          owner_vld[p] <= 1'b1;
          owner_idx[p] <= gnt_idx;
        end
      end

      for (int i = 0; i < int'(N_REQ); i++) begin
        if (release_c[i]) begin
          mutex_val[i*N_PORT +: N_PORT] <= '0;
        end else if (gnt_vld && (gnt_idx == IW'(i))) begin
          mutex_val[i*N_PORT +: N_PORT] <= req_m[i];
        end
      end

      if (gnt_vld) begin
        rr_ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      end

      // Hold watchdog is status only; it never revokes ownership.
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (release_c[i]) begin
          hold_cnt[i]     <= '0;
          hold_overrun[i] <= 1'b0;
        end else if ((MAX_HOLD != 0) && holding[i]) begin
          if (hold_cnt[i] != HW'(MAX_HOLD)) hold_cnt[i] <= hold_cnt[i] + HW'(1);
          if (hold_cnt[i] >= HW'(HOLD_LIM)) hold_overrun[i] <= 1'b1;
        end
      end
    end
  end

endmodule
